// File: rtl/serial_divider_pkg.sv
// ============================================================================
// Module      : serial_divider_pkg
// Description : Shared constants and types for the serial divider Wishbone
//               initiator: register map, control/status bit positions and
//               the sequencing FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_divider_pkg;

    // Register map of the divider slave. Operand/result registers live in
    // the top nibble, control/status in the next one, so no address mixes both.
    localparam logic [31:0] c_ADR_DIVIDEND  = 32'h1000_0000;
    localparam logic [31:0] c_ADR_DIVISOR   = 32'h2000_0000;
    localparam logic [31:0] c_ADR_QUOTIENT  = 32'h3000_0000;
    localparam logic [31:0] c_ADR_REMAINDER = 32'h4000_0000;
    localparam logic [31:0] c_ADR_CTRL      = 32'h0100_0000;
    localparam logic [31:0] c_ADR_STATUS    = 32'h0200_0000;

    // Bit positions inside CTRL and STATUS
    localparam int c_CTRL_START_BIT  = 0;
    localparam int c_STATUS_DONE_BIT = 0;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_DVD    = 4'd1,
        S_WR_DVS    = 4'd2,
        S_WR_GO     = 4'd3,
        S_RD_STAT   = 4'd4,
        S_POLL_WAIT = 4'd5,
        S_RD_QUO    = 4'd6,
        S_RD_REM    = 4'd7,
        S_RESP      = 4'd8
    } state_t;

endpackage : serial_divider_pkg

`default_nettype wire

// File: rtl/wb_single_xfer.sv
// ============================================================================
// Module      : wb_single_xfer
// Description : One Wishbone classic read or write cycle. Holds cyc/stb from
//               the cycle after start until ack, then forces at least one
//               idle cycle before the next transfer may begin.
//               Optional bus timeout: SERIAL_DIV_WBM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_single_xfer #(
    parameter int WBW         = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_we,
    input  logic [WBW-1:0] i_adr,
    input  logic [WBW-1:0] i_dat,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic [WBW-1:0] o_rdata,
    output logic           o_wb_cyc,
    output logic           o_wb_stb,
    output logic           o_wb_we,
    output logic [WBW-1:0] o_wb_adr,
    output logic [WBW-1:0] o_wb_dat,
    input  logic           i_wb_ack,
    input  logic [WBW-1:0] i_wb_dat
);

    localparam logic [1:0] X_IDLE = 2'd0;
    localparam logic [1:0] X_BUS  = 2'd1;
    localparam logic [1:0] X_GAP  = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_next;
    logic           w_accept;
    logic           w_tmo;
    logic           r_we;
    logic [WBW-1:0] r_adr;
    logic [WBW-1:0] r_dat;

    // A new transfer is taken whenever the bus is not currently strobed
    assign w_accept = i_start && (r_state != X_BUS);

    // State register; async reset drops cyc/stb immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= X_IDLE;
        else     r_state <= w_next;
    end

    // Next state: GAP is the mandatory idle cycle after every ack or timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            X_IDLE:  if (i_start) w_next = X_BUS;
            X_BUS:   if (i_wb_ack || w_tmo) w_next = X_GAP;
            X_GAP:   w_next = i_start ? X_BUS : X_IDLE;
            default: w_next = X_IDLE;
        endcase
    end

    // Bus and handshake outputs decoded from state
    always_comb begin
        o_busy   = (r_state == X_BUS);
        o_wb_cyc = (r_state == X_BUS);
        o_wb_stb = (r_state == X_BUS);
        o_done   = (r_state == X_BUS) && i_wb_ack;
        o_err    = (r_state == X_BUS) && !i_wb_ack && w_tmo;
        o_rdata  = i_wb_dat;
        o_wb_we  = r_we;
        o_wb_adr = r_adr;
        o_wb_dat = r_dat;
    end

    // Address/data/we frozen at start so they stay stable while stb is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (w_accept) begin
            r_we  <= i_we;
            r_adr <= i_adr;
            r_dat <= i_dat;
        end
    end

`ifdef SERIAL_DIV_WBM_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
    logic [c_TW-1:0] r_tmo_cnt;

    // Counts strobed cycles without ack; fires on the TIMEOUT_CYC-th one
    assign w_tmo = (r_tmo_cnt == c_TW'(TIMEOUT_CYC - 1));

    // Timeout counter: runs only while strobing, cleared on ack or idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_tmo_cnt <= '0;
        else if (r_state != X_BUS || i_wb_ack)  r_tmo_cnt <= '0;
        else                                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

endmodule : wb_single_xfer

`default_nettype wire

// File: rtl/serial_divider_wb_master.sv
// ============================================================================
// Module      : serial_divider_wb_master
// Description : Wishbone classic initiator that runs a complete division on
//               the serial_divider slave: write operands, start, poll status,
//               read quotient and remainder, return them on a valid/ready
//               response port. Divide-by-zero is answered locally.
//               Optional bus timeout: SERIAL_DIV_WBM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_divider_wb_master
    import serial_divider_pkg::*;
#(
    parameter int WBW         = 32,
    parameter int XLEN        = 32,
    parameter int POLL_GAP    = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [XLEN-1:0]  req_dividend_i,
    input  logic [XLEN-1:0]  req_divisor_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_quotient_o,
    output logic [XLEN-1:0]  rsp_remainder_o,
    output logic             rsp_dbz_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WBW/8-1:0] wbm_sel_o,
    output logic [WBW-1:0]   wbm_adr_o,
    output logic [WBW-1:0]   wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [WBW-1:0]   wbm_dat_i,
    output logic             busy_o
);

    localparam int c_PW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_t          r_state;
    state_t          w_next;
    logic            r_alive;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic            r_dbz;
    logic            r_err;
    logic [c_PW-1:0] r_poll_cnt;

    logic            w_accept;
    logic            w_bus_state;
    logic            w_poll_last;
    logic            w_x_start;
    logic            w_x_we;
    logic [WBW-1:0]  w_x_adr;
    logic [WBW-1:0]  w_x_dat;
    logic            w_x_busy;
    logic            w_x_done;
    logic            w_x_err;
    logic [WBW-1:0]  w_x_rdata;

    assign w_accept    = req_valid_i && req_ready_o;
    assign w_poll_last = (r_poll_cnt == c_PW'(POLL_GAP - 1));
    assign w_bus_state = (r_state == S_WR_DVD) || (r_state == S_WR_DVS) ||
                         (r_state == S_WR_GO)  || (r_state == S_RD_STAT) ||
                         (r_state == S_RD_QUO) || (r_state == S_RD_REM);

    // State register; r_alive keeps req_ready low while reset is applied
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
        end
    end

    // Next state: each bus state advances on its transfer ack, any timeout aborts
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next = (req_divisor_i == '0) ? S_RESP : S_WR_DVD;
            S_WR_DVD:    if (w_x_err) w_next = S_RESP; else if (w_x_done) w_next = S_WR_DVS;
            S_WR_DVS:    if (w_x_err) w_next = S_RESP; else if (w_x_done) w_next = S_WR_GO;
            S_WR_GO:     if (w_x_err) w_next = S_RESP; else if (w_x_done) w_next = S_RD_STAT;
            S_RD_STAT: begin
                if (w_x_err)       w_next = S_RESP;
                else if (w_x_done) w_next = w_x_rdata[c_STATUS_DONE_BIT] ? S_RD_QUO : S_POLL_WAIT;
            end
            S_POLL_WAIT: if (w_poll_last) w_next = S_RD_STAT;
            S_RD_QUO:    if (w_x_err) w_next = S_RESP; else if (w_x_done) w_next = S_RD_REM;
            S_RD_REM:    if (w_x_err) w_next = S_RESP; else if (w_x_done) w_next = S_RESP;
            S_RESP:      if (rsp_ready_i) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Outputs and transfer request; the last poll-wait cycle pre-issues the
    // status read so the bus sees exactly POLL_GAP idle cycles between polls
    always_comb begin
        req_ready_o = (r_state == S_IDLE) && r_alive;
        busy_o      = (r_state != S_IDLE);
        rsp_valid_o = (r_state == S_RESP);
        w_x_start   = (w_bus_state && !w_x_busy) ||
                      ((r_state == S_POLL_WAIT) && w_poll_last);
        w_x_we      = 1'b0;
        w_x_adr     = '0;
        w_x_dat     = '0;
        case (r_state)
            S_WR_DVD: begin
                w_x_we               = 1'b1;
                w_x_adr              = WBW'(c_ADR_DIVIDEND);
                w_x_dat[XLEN-1:0]    = r_dvd;
            end
            S_WR_DVS: begin
                w_x_we               = 1'b1;
                w_x_adr              = WBW'(c_ADR_DIVISOR);
                w_x_dat[XLEN-1:0]    = r_dvs;
            end
            S_WR_GO: begin
                w_x_we                    = 1'b1;
                w_x_adr                   = WBW'(c_ADR_CTRL);
                w_x_dat[c_CTRL_START_BIT] = 1'b1;
            end
            S_RD_STAT, S_POLL_WAIT: w_x_adr = WBW'(c_ADR_STATUS);
            S_RD_QUO:               w_x_adr = WBW'(c_ADR_QUOTIENT);
            S_RD_REM:               w_x_adr = WBW'(c_ADR_REMAINDER);
            default:                w_x_adr = '0;
        endcase
    end

    // Operand capture, result capture and poll-gap counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_err      <= 1'b0;
            r_poll_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_dvd <= req_dividend_i;
                r_dvs <= req_divisor_i;
                r_err <= 1'b0;
                if (req_divisor_i == '0) begin
                    r_dbz <= 1'b1;
                    r_quo <= '1;
                    r_rem <= req_dividend_i;
                end else begin
                    r_dbz <= 1'b0;
                    r_quo <= '0;
                    r_rem <= '0;
                end
            end
            if (w_x_err) begin
                r_err <= 1'b1;
                r_quo <= '0;
                r_rem <= '0;
            end
            if (w_x_done && (r_state == S_RD_QUO)) r_quo <= w_x_rdata[XLEN-1:0];
            if (w_x_done && (r_state == S_RD_REM)) r_rem <= w_x_rdata[XLEN-1:0];
            if (r_state == S_POLL_WAIT) r_poll_cnt <= r_poll_cnt + 1'b1;
            else                        r_poll_cnt <= '0;
        end
    end

    assign rsp_quotient_o  = r_quo;
    assign rsp_remainder_o = r_rem;
    assign rsp_dbz_o       = r_dbz;
    assign rsp_err_o       = r_err;
    assign wbm_sel_o       = '1;

    wb_single_xfer #(
        .WBW         (WBW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_xfer (
        .clk      (clk_i),
        .rst      (reset_i),
        .i_start  (w_x_start),
        .i_we     (w_x_we),
        .i_adr    (w_x_adr),
        .i_dat    (w_x_dat),
        .o_busy   (w_x_busy),
        .o_done   (w_x_done),
        .o_err    (w_x_err),
        .o_rdata  (w_x_rdata),
        .o_wb_cyc (wbm_cyc_o),
        .o_wb_stb (wbm_stb_o),
        .o_wb_we  (wbm_we_o),
        .o_wb_adr (wbm_adr_o),
        .o_wb_dat (wbm_dat_o),
        .i_wb_ack (wbm_ack_i),
        .i_wb_dat (wbm_dat_i)
    );

endmodule : serial_divider_wb_master

`default_nettype wire

// File: tb/tb_serial_divider_wb_master.sv
// ============================================================================
// Module      : tb_serial_divider_wb_master
// Description : Self-checking bench: Wishbone divider slave model, bus
//               protocol monitor and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_divider_wb_master;
    import serial_divider_pkg::*;

    localparam int WBW         = 32;
    localparam int XLEN        = 32;
    localparam int POLL_GAP    = 4;
    localparam int TIMEOUT_CYC = 1024;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            req_valid_i, req_ready_o;
    logic [XLEN-1:0] req_dividend_i, req_divisor_i;
    logic            rsp_valid_o, rsp_ready_i;
    logic [XLEN-1:0] rsp_quotient_o, rsp_remainder_o;
    logic            rsp_dbz_o, rsp_err_o;
    logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [WBW/8-1:0] wbm_sel_o;
    logic [WBW-1:0]  wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic            wbm_ack_i;
    logic            busy_o;

    always #5 clk = ~clk;

    serial_divider_wb_master #(
        .WBW(WBW), .XLEN(XLEN), .POLL_GAP(POLL_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_quotient_o(rsp_quotient_o), .rsp_remainder_o(rsp_remainder_o),
        .rsp_dbz_o(rsp_dbz_o), .rsp_err_o(rsp_err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy_o(busy_o)
    );

    // ---------------- divider slave model ----------------
    logic [31:0] s_dvd, s_dvs, s_q, s_r;
    int          s_polls_left = 0;
    int          s_polls_cfg  = 1;
    bit          s_never_ack  = 1'b0;

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wbm_ack_i <= 1'b0;
        end else begin
            wbm_ack_i <= wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !s_never_ack;
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                if (wbm_we_o) begin
                    if (wbm_adr_o == c_ADR_DIVIDEND) s_dvd <= wbm_dat_o;
                    if (wbm_adr_o == c_ADR_DIVISOR)  s_dvs <= wbm_dat_o;
                    if (wbm_adr_o == c_ADR_CTRL && wbm_dat_o[0]) begin
                        s_q          <= s_dvd / s_dvs;
                        s_r          <= s_dvd % s_dvs;
                        s_polls_left <= s_polls_cfg - 1;
                    end
                end else if (wbm_adr_o == c_ADR_STATUS && s_polls_left > 0) begin
                    s_polls_left <= s_polls_left - 1;
                end
            end
        end
    end

    always_comb begin
        wbm_dat_i = '0;
        if (wbm_adr_o == c_ADR_STATUS)    wbm_dat_i[0] = (s_polls_left == 0);
        if (wbm_adr_o == c_ADR_QUOTIENT)  wbm_dat_i = s_q;
        if (wbm_adr_o == c_ADR_REMAINDER) wbm_dat_i = s_r;
    end

    // ---------------- bus monitor ----------------
    int          n_wr = 0, n_rd_stat = 0, n_rd_data = 0, n_xfer = 0;
    int          gap_run = 1, gap_viol = 0, stab_viol = 0;
    int          stb_run = 0, last_stb_run = 0;
    int          poll_gaps[$];
    bit          prev_stb = 1'b0, last_was_stat = 1'b0;
    logic [31:0] m_adr, m_dat;
    logic        m_we;

    always @(negedge clk) begin
        if (reset_i) begin
            prev_stb      = 1'b0;
            gap_run       = 1;
            last_was_stat = 1'b0;
        end else if (wbm_stb_o) begin
            if (!prev_stb) begin
                n_xfer++;
                if (gap_run < 1) gap_viol++;
                if (wbm_we_o) n_wr++;
                else if (wbm_adr_o == c_ADR_STATUS) begin
                    if (last_was_stat) poll_gaps.push_back(gap_run);
                    n_rd_stat++;
                end else n_rd_data++;
                last_was_stat = !wbm_we_o && (wbm_adr_o == c_ADR_STATUS);
                m_adr = wbm_adr_o; m_dat = wbm_dat_o; m_we = wbm_we_o;
                stb_run = 1;
            end else begin
                if (wbm_adr_o !== m_adr || wbm_dat_o !== m_dat || wbm_we_o !== m_we) stab_viol++;
                stb_run++;
            end
            if (wbm_cyc_o !== 1'b1 || wbm_sel_o !== 4'hF) stab_viol++;
            gap_run = 0;
        end else begin
            if (prev_stb) last_stb_run = stb_run;
            gap_run++;
        end
        prev_stb = wbm_stb_o;
    end

    // ---------------- scoreboard and checks ----------------
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        n_wr = 0; n_rd_stat = 0; n_rd_data = 0; n_xfer = 0;
        gap_viol = 0; stab_viol = 0;
        poll_gaps.delete();
    endtask

    task automatic send_req(input logic [31:0] dvd, input logic [31:0] dvs,
                            input bit err_exp, input bit push);
        exp_t e;
        int   k;
        if (dvs == 0)     begin e.q = '1; e.r = dvd;       e.dbz = 1'b1; e.err = 1'b0; end
        else if (err_exp) begin e.q = '0; e.r = '0;        e.dbz = 1'b0; e.err = 1'b1; end
        else              begin e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 1'b0; e.err = 1'b0; end
        if (push) sb.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b1; req_dividend_i = dvd; req_divisor_i = dvs;
        k = 0;
        while (!req_ready_o && k < 200) begin @(negedge clk); k++; end
        chk("req_accept", {63'd0, req_ready_o}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance: the DUT must use captured operands
        req_valid_i = 1'b0; req_dividend_i = ~dvd; req_divisor_i = dvs + 32'd1;
    endtask

    task automatic get_rsp(input string tag, input int hold, output int lat);
        exp_t        e;
        bit          ok;
        logic [31:0] q0, r0;
        lat = 0;
        while (!rsp_valid_o && lat < 5000) begin @(negedge clk); lat++; end
        chk({tag, "_rsp_seen"}, {63'd0, rsp_valid_o}, 64'd1);
        if (rsp_valid_o && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_q"},   {32'd0, rsp_quotient_o},  {32'd0, e.q});
            chk({tag, "_r"},   {32'd0, rsp_remainder_o}, {32'd0, e.r});
            chk({tag, "_dbz"}, {63'd0, rsp_dbz_o},       {63'd0, e.dbz});
            chk({tag, "_err"}, {63'd0, rsp_err_o},       {63'd0, e.err});
            if (hold > 0) begin
                ok = 1'b1; q0 = rsp_quotient_o; r0 = rsp_remainder_o;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    if (!rsp_valid_o || rsp_quotient_o !== q0 || rsp_remainder_o !== r0 ||
                        req_ready_o || wbm_cyc_o || !busy_o) ok = 1'b0;
                end
                chk({tag, "_hold_stable"}, {63'd0, ok}, 64'd1);
            end
            rsp_ready_i = 1'b1;
            @(negedge clk);
            rsp_ready_i = 1'b0;
            chk({tag, "_idle_after"}, {61'd0, rsp_valid_o, busy_o, req_ready_o}, 64'd1);
        end
    endtask

    initial begin
        int          lat;
        int          k;
        logic [31:0] a, b;
        bit          saw_rsp;

        reset_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        req_dividend_i = '0; req_divisor_i = '0;
        #12;
        chk("reset_ctrl", {56'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, req_ready_o,
                           rsp_valid_o, busy_o, rsp_dbz_o, rsp_err_o}, 64'd0);
        chk("reset_bus", {wbm_adr_o, wbm_dat_o}, 64'd0);
        chk("reset_rsp", {rsp_quotient_o, rsp_remainder_o}, 64'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {63'd0, req_ready_o}, 64'd1);

        // 100/25, done on first poll
        clear_log(); s_polls_cfg = 1;
        send_req(32'd100, 32'd25, 1'b0, 1'b1);
        get_rsp("t1", 0, lat);
        chk("t1_writes", n_wr, 3);
        chk("t1_stat_reads", n_rd_stat, 1);
        chk("t1_data_reads", n_rd_data, 2);

        // max dividend, done on third poll, poll spacing
        clear_log(); s_polls_cfg = 3;
        send_req(32'hFFFF_FFFF, 32'd16, 1'b0, 1'b1);
        get_rsp("t2", 0, lat);
        chk("t2_stat_reads", n_rd_stat, 3);
        chk("t2_poll_gap_count", poll_gaps.size(), 2);
        foreach (poll_gaps[i]) chk("t2_poll_gap", poll_gaps[i], POLL_GAP);
        chk("t2_gap_viol", gap_viol, 0);
        chk("t2_stab_viol", stab_viol, 0);

        // divide by zero: immediate response, no bus traffic
        clear_log();
        send_req(32'd7, 32'd0, 1'b0, 1'b1);
        get_rsp("t3", 0, lat);
        chk("t3_latency", lat, 0);
        chk("t3_no_bus", n_xfer, 0);

        // response back-pressure for 10 cycles
        clear_log(); s_polls_cfg = 2;
        send_req(32'd1000, 32'd7, 1'b0, 1'b1);
        get_rsp("t4", 10, lat);

        // a few random operand patterns
        for (int i = 0; i < 3; i++) begin
            clear_log();
            a = $urandom; b = $urandom_range(1, 50000);
            s_polls_cfg = $urandom_range(1, 3);
            send_req(a, b, 1'b0, 1'b1);
            get_rsp("rnd", 0, lat);
            chk("rnd_gap_viol", gap_viol + stab_viol, 0);
        end

        // reset while strobing the divisor write
        clear_log(); s_polls_cfg = 1;
        send_req(32'd50, 32'd5, 1'b0, 1'b0);
        k = 0; saw_rsp = 1'b0;
        while (!(wbm_stb_o && wbm_adr_o == c_ADR_DIVISOR) && k < 100) begin
            @(negedge clk); k++;
            if (rsp_valid_o) saw_rsp = 1'b1;
        end
        chk("t5_reach_wr_dvs", {63'd0, wbm_stb_o}, 64'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("t5_async_drop", {60'd0, wbm_cyc_o, wbm_stb_o, busy_o, rsp_valid_o}, 64'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_no_rsp", {63'd0, saw_rsp | rsp_valid_o}, 64'd0);
        clear_log();
        send_req(32'd9, 32'd3, 1'b0, 1'b1);
        get_rsp("t5", 0, lat);
        chk("t5_writes", n_wr, 3);

`ifdef SERIAL_DIV_WBM_TIMEOUT_EN
        // slave never acks: timeout response after TIMEOUT_CYC strobed cycles
        clear_log(); s_never_ack = 1'b1;
        send_req(32'd5, 32'd1, 1'b1, 1'b1);
        get_rsp("t6", 0, lat);
        chk("t6_stb_len", last_stb_run, TIMEOUT_CYC);
        chk("t6_gap_viol", gap_viol, 0);
        s_never_ack = 1'b0;
`endif

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_divider_wb_master

`default_nettype wire
